ram_arb2: RTL

Two-client arbiter and sequencer for the `ram_dual` simple dual-port RAM (D_WIDTH x 2**A_WIDTH).
- Grants at most one access (read or write) per cycle to one of two requesters.
- Drives the RAM write and read ports.
- Returns read data to the granted client one cycle later, tagged with a valid strobe.
- Bounded-burst round-robin, so a streaming client (e.g. capture) cannot starve a control client.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb2_if.sv | 44 ++++
 rtl/ram_arb2_rr_pick2.sv | 55 +++++
 rtl/ram_arb2.sv | 113 +++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM arbiter ram_arb2.
// Holds the owner state encoding, client ids and the default burst length.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    localparam int BURST_DEF = 4;

endpackage

// File: rtl/ram_arb2_if.sv
// Client and RAM-side bus of ram_arb2 (owner state is exported for debug).
// Handshake: a client holds cX_req with we/addr/wdata stable until it sees cX_gnt high in the same cycle; the access occurs on that edge and read data returns one cycle later on cX_rvalid/cX_rdata.
interface ram_arb2_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5
);
    logic               c0_req;
    logic               c1_req;
    logic               c0_we;
    logic               c1_we;
    logic [A_WIDTH-1:0] c0_addr;
    logic [A_WIDTH-1:0] c1_addr;
    logic [D_WIDTH-1:0] c0_wdata;
    logic [D_WIDTH-1:0] c1_wdata;
    logic               c0_gnt;
    logic               c1_gnt;
    logic               c0_rvalid;
    logic               c1_rvalid;
    logic [D_WIDTH-1:0] c0_rdata;
    logic [D_WIDTH-1:0] c1_rdata;
    logic               ram_wen;
    logic [A_WIDTH-1:0] ram_waddr;
    logic [D_WIDTH-1:0] ram_wdata;
    logic [A_WIDTH-1:0] ram_raddr;
    logic [D_WIDTH-1:0] ram_rdata;
    ram_arb_pkg::owner_t owner_dbg;

    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        output ram_wen, ram_waddr, ram_wdata, ram_raddr,
        input  ram_rdata,
        output owner_dbg
    );

    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        input  ram_wen, ram_waddr, ram_wdata, ram_raddr,
        output ram_rdata,
        input  owner_dbg
    );

endinterface

// File: rtl/ram_arb2_rr_pick2.sv
// rr_pick2: combinational 2-way winner select for ram_arb2 (bounded-burst round-robin).
// Build option RAM_ARB_FIXED_PRI_EN switches to client-0 priority with a burst cap on client 0.
module rr_pick2
    import ram_arb_pkg::*;
#(
    parameter int BURST = BURST_DEF
) (
    input  logic       req0,
    input  logic       req1,
    input  owner_t     owner,
    input  logic [3:0] cnt,
    input  logic       last,
    output logic       gnt0,
    output logic       gnt1
);

    logic below;
    assign below = (cnt < 4'(BURST));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (owner)
            OWN0: begin
                if (req0 && (below || !req1)) gnt0 = 1'b1;
                else if (req1)                gnt1 = 1'b1;
            end
            OWN1: begin
`ifdef RAM_ARB_FIXED_PRI_EN
                // Client 1 only keeps the RAM while client 0 is silent.
                if (req0)      gnt0 = 1'b1;
                else if (req1) gnt1 = 1'b1;
`else
                if (req1 && (below || !req0)) gnt1 = 1'b1;
                else if (req0)                gnt0 = 1'b1;
`endif
            end
            default: begin
`ifdef RAM_ARB_FIXED_PRI_EN
                if (req0)      gnt0 = 1'b1;
                else if (req1) gnt1 = 1'b1;
`else
                if (req0 && req1) begin
                    gnt0 = (last == CLIENT1);
                    gnt1 = (last == CLIENT0);
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
`endif
            end
        endcase
    end

endmodule

// File: rtl/ram_arb2.sv
// ram_arb2: two-client arbiter/sequencer for a simple dual-port RAM with 1-cycle registered read.
// Optional build macro RAM_ARB_FIXED_PRI_EN (handled in rr_pick2) gives client 0 priority.
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int BURST   = BURST_DEF
) (
    input logic       clk,
    input logic       rst_n,
    ram_arb2_if.slave bus
);

    owner_t             owner;
    logic [3:0]         cnt;
    logic [3:0]         cnt_inc;
    logic               last;
    logic               rd_vld;
    logic               rd_id;
    logic [A_WIDTH-1:0] waddr_q;
    logic [A_WIDTH-1:0] raddr_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic [D_WIDTH-1:0] rdata0_q;
    logic [D_WIDTH-1:0] rdata1_q;
    logic [D_WIDTH-1:0] rdata0_d;
    logic [D_WIDTH-1:0] rdata1_d;
    logic               gnt0;
    logic               gnt1;
    logic               gnt_any;
    logic               sel_we;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_wdata;
    logic               wr;
    logic               rd;
    logic               rv0;
    logic               rv1;

    rr_pick2 #(.BURST(BURST)) u_pick (
        .req0  (bus.c0_req),
        .req1  (bus.c1_req),
        .owner (owner),
        .cnt   (cnt),
        .last  (last),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? bus.c1_we    : bus.c0_we;
    assign sel_addr  = gnt1 ? bus.c1_addr  : bus.c0_addr;
    assign sel_wdata = gnt1 ? bus.c1_wdata : bus.c0_wdata;
    assign wr        = gnt_any &  sel_we;
    assign rd        = gnt_any & ~sel_we;
    assign cnt_inc   = (cnt >= 4'(BURST)) ? 4'(BURST) : cnt + 4'd1;

    // Address/data lines hold their last used value so the RAM ports stay quiet when idle.
    assign bus.ram_wen   = wr;
    assign bus.ram_waddr = wr ? sel_addr  : waddr_q;
    assign bus.ram_wdata = wr ? sel_wdata : wdata_q;
    assign bus.ram_raddr = rd ? sel_addr  : raddr_q;

    assign rv0      = rd_vld && (rd_id == CLIENT0);
    assign rv1      = rd_vld && (rd_id == CLIENT1);
    assign rdata0_d = rv0 ? bus.ram_rdata : rdata0_q;
    assign rdata1_d = rv1 ? bus.ram_rdata : rdata1_q;

    assign bus.c0_gnt    = gnt0;
    assign bus.c1_gnt    = gnt1;
    assign bus.c0_rvalid = rv0;
    assign bus.c1_rvalid = rv1;
    assign bus.c0_rdata  = rdata0_d;
    assign bus.c1_rdata  = rdata1_d;
    assign bus.owner_dbg = owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= IDLE;
            cnt      <= 4'd0;
            last     <= CLIENT1;
            rd_vld   <= 1'b0;
            rd_id    <= CLIENT0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            raddr_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (gnt0) begin
                owner <= OWN0;
                cnt   <= (owner == OWN0) ? cnt_inc : 4'd1;
                last  <= CLIENT0;
            end else if (gnt1) begin
                owner <= OWN1;
                cnt   <= (owner == OWN1) ? cnt_inc : 4'd1;
                last  <= CLIENT1;
            end else begin
                owner <= IDLE;
                cnt   <= 4'd0;
            end
            rd_vld <= rd;
            rd_id  <= gnt1;
            if (wr) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (rd) raddr_q <= sel_addr;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule
